// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier producing a 2*WIDTH-bit HI/LO product.
// Signed operands are multiplied as magnitudes and the product is negated at the end.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      count_q, count_d;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] result;

  // |most-negative| wraps to itself, which is the correct unsigned magnitude.
  assign mag_a     = (is_signed && input_a[WIDTH-1]) ? -input_a : input_a;
  assign mag_b     = (is_signed && input_b[WIDTH-1]) ? -input_b : input_b;
  assign accept    = start && (state_q == IDLE || state_q == FINISH);
  assign last_iter = (count_q == CW'(WIDTH - 1));
  assign sum       = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign product   = {sum, mplier_q[WIDTH-1:1]};
  assign result    = neg_q ? -product : product;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      count_q  <= count_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = FINISH;
      FINISH:  state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    count_d  = count_q;
    if (accept) begin
      mcand_d  = mag_a;
      mplier_d = mag_b;
      neg_d    = (input_a[WIDTH-1] ^ input_b[WIDTH-1]) & is_signed;
      acc_d    = '0;
      count_d  = '0;
    end else if (state_q == RUN) begin
      // Right-shift the {carry, accumulator, multiplier} chain by one.
      acc_d    = sum[WIDTH:1];
      mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
      count_d  = count_q + CW'(1);
      if (last_iter) begin
        hi_d = result[2*WIDTH-1:WIDTH];
        lo_d = result[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FINISH);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: directed operand vectors with hand-computed
// products, handshake timing, back-to-back issue and mid-operation reset.
module tb_mult_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] sb[$];

  mult_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .input_a  (input_a),
    .input_b  (input_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every done against the oldest expected product.
  always @(negedge clock) begin
    if (!reset && done) begin
      check("busy_with_done", {63'b0, busy}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(sb.size()), 64'd1);
      end else begin
        check("product", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Called #1 after an edge; start is sampled at the next edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    start     = 1'b1;
    is_signed = s;
    input_a   = a;
    input_b   = b;
    if (push) sb.push_back(exp);
    @(posedge clock);
    #1;
    start     = 1'b0;
    is_signed = ~s;
    input_a   = $urandom;
    input_b   = $urandom;
  endtask

  // Waits for done after the start edge; optionally re-pulses start mid-RUN.
  task automatic wait_done(input string name, input int glitch_at);
    int cycles = 0;
    int busy_cnt = 0;
    bit held = 1'b1;
    logic [63:0] prev = {hi, lo};
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if ({hi, lo} !== prev) held = 1'b0;
      if (cycles == glitch_at) begin
        start   = 1'b1;
        input_a = 32'd9;
        input_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      cycles++;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(cycles), 64'd32);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({name, "_hold"}, {63'b0, held}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    issue(s, a, b, exp, 1'b1);
    wait_done(name, -1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int done_cnt;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    input_a   = '0;
    input_b   = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_op("u_small",      1'b0, 32'd7,        32'd6,        64'h00000000_0000002A);
    run_op("u_max",        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("s_neg",        1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1);
    run_op("u_no_negate",  1'b0, 32'hFFFFFFFD, 32'd5,        64'h00000004_FFFFFFF1);
    run_op("s_both_neg",   1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'h00000000_00000006);
    run_op("s_min_sq",     1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("s_min_one",    1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000);

    // Handshake: start during RUN is ignored, start in FINISH issues immediately.
    issue(1'b0, 32'd3, 32'd4, 64'd12, 1'b1);
    wait_done("hs_first", 10);
    issue(1'b0, 32'd2, 32'd5, 64'd10, 1'b1);
    wait_done("hs_b2b", -1);
    @(posedge clock);
    #1;

    // Reset in the middle of RUN aborts the operation.
    issue(1'b0, 32'd100, 32'd100, 64'd10000, 1'b0);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
